// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: frame geometry, data widths and the
// result writer state encoding.
package img_pkg;

  localparam int unsigned FrameWidth  = 64;
  localparam int unsigned FrameHeight = 64;
  localparam int unsigned AddrW       = 12;
  localparam int unsigned DataW       = 13;
  localparam int unsigned PixelMax    = 255;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StFinish
  } writer_state_e;

endpackage

// File: rtl/pixel_clamp.sv
// Combinational saturation of a two's complement value to the 0..PixelMax
// pixel range, zero-extended back to the input width.
module pixel_clamp
  import img_pkg::*;
#(
  parameter int unsigned DATA_W = DataW
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    if (data_i[DATA_W-1]) begin
      data_o = '0;
    end else if (data_i > DATA_W'(PixelMax)) begin
      data_o = DATA_W'(PixelMax);
    end else begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/kernel_result_writer.sv
// Writes a full output frame into the result RAM: constant border pixels are
// generated locally, interior pixels come from the kernel result stream.
module kernel_result_writer
  import img_pkg::*;
#(
  parameter int unsigned WIDTH        = FrameWidth,
  parameter int unsigned HEIGHT       = FrameHeight,
  parameter int unsigned ADDR_W       = AddrW,
  parameter int unsigned DATA_W       = DataW,
  parameter int unsigned BORDER_VALUE = 0,
  parameter bit          CLAMP        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  writer_state_e state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              wr_en_d, busy_d, done_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  logic              last_col, last_row, border, advance;
  logic [DATA_W-1:0] clamped, result;

  pixel_clamp #(
    .DATA_W(DATA_W)
  ) u_clamp (
    .data_i(in_data),
    .data_o(clamped)
  );

  assign last_col = (col_q == ColW'(WIDTH - 1));
  assign last_row = (row_q == RowW'(HEIGHT - 1));
  assign border   = (row_q == '0) || last_row || (col_q == '0) || last_col;
  assign result   = CLAMP ? clamped : in_data;

  // Border positions never consume from the stream; they always advance.
  assign in_ready = (state_q == StWrite) && !border;
  assign advance  = (state_q == StWrite) && (border || in_valid);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = 1'b0;
    wr_en_d   = advance;
    wr_addr_d = ADDR_W'(row_q * WIDTH + col_q);
    wr_data_d = border ? DATA_W'(BORDER_VALUE) : result;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrite;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StWrite: begin
        if (advance) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = StFinish;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_kernel_result_writer.sv
// Bench for kernel_result_writer: two instances (clamping with border 0,
// pass-through with border 7) share one stimulus stream and a frame-level model.
module tb_kernel_result_writer;

  localparam int W = 64;
  localparam int H = 64;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [12:0] in_data;

  logic        in_ready0, wr_en0, busy0, done0;
  logic [11:0] wr_addr0;
  logic [12:0] wr_data0;
  logic        in_ready1, wr_en1, busy1, done1;
  logic [11:0] wr_addr1;
  logic [12:0] wr_data1;

  kernel_result_writer #(
    .WIDTH(64), .HEIGHT(64), .ADDR_W(12), .DATA_W(13), .BORDER_VALUE(0), .CLAMP(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0)
  );

  kernel_result_writer #(
    .WIDTH(64), .HEIGHT(64), .ADDR_W(12), .DATA_W(13), .BORDER_VALUE(7), .CLAMP(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame model: phase 0 idle, 1 writing linear position m_pos, 2 finishing.
  int m_phase, m_pos;
  bit e_wr, e_done, e_busy;
  int e_addr, e_d0, e_d1;

  logic [12:0] mem0 [NPIX];
  logic [12:0] mem1 [NPIX];
  int g_nwr, g_hs, g_ndone, g_first_wr_after, g_ready_border;
  int g_done_cyc [2];

  logic [12:0] clamp_vec [5] = '{13'h1FFB, 13'd0, 13'd255, 13'd300, 13'd4095};

  function automatic bit is_interior(input int pos);
    int r, c;
    r = pos / W;
    c = pos % W;
    return (r >= 1) && (r <= H - 2) && (c >= 1) && (c <= W - 2);
  endfunction

  function automatic int clamp_ref(input logic [12:0] v);
    int s;
    s = $signed(v);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  // dmode: 0 row*100+col, 1 random, 2 clamp vectors then row*100+col
  // vmode: 0 always valid, 1 random valid, 2 ten-cycle stall at (5,5)
  task automatic run_frame(input int dmode, input int vmode, input int rst_at,
                           input int extra_start, input bit b2b);
    int cyc, frames_left, stall_cnt, r, c, n_a, n_d0, n_d1;
    bit fin, cur_done, exp_ready, adv, n_wr, n_done;
    foreach (mem0[i]) begin
      mem0[i] = 'x;
      mem1[i] = 'x;
    end
    g_nwr = 0; g_hs = 0; g_ndone = 0; g_first_wr_after = -1; g_ready_border = 0;
    g_done_cyc[0] = -1; g_done_cyc[1] = -1;
    frames_left = b2b ? 2 : 1;
    stall_cnt = 0;
    cyc = 0;
    fin = 0;
    while (!fin) begin
      @(posedge clk);
      #1;
      exp_ready = (m_phase == 1) && is_interior(m_pos);
      checks += 6;
      if (in_ready0 !== exp_ready) begin
        errors++; $display("FAIL in_ready0 cyc %0d got %b exp %b", cyc, in_ready0, exp_ready);
      end
      if (in_ready1 !== exp_ready) begin
        errors++; $display("FAIL in_ready1 cyc %0d got %b exp %b", cyc, in_ready1, exp_ready);
      end
      if (wr_en0 !== e_wr || wr_en1 !== e_wr) begin
        errors++; $display("FAIL wr_en cyc %0d got %b/%b exp %b", cyc, wr_en0, wr_en1, e_wr);
      end
      if (busy0 !== e_busy || busy1 !== e_busy) begin
        errors++; $display("FAIL busy cyc %0d got %b/%b exp %b", cyc, busy0, busy1, e_busy);
      end
      if (done0 !== e_done || done1 !== e_done) begin
        errors++; $display("FAIL done cyc %0d got %b/%b exp %b", cyc, done0, done1, e_done);
      end
      if (m_phase == 1 && !is_interior(m_pos) && in_ready0 === 1'b1) g_ready_border++;
      if (e_wr) begin
        checks += 2;
        if (wr_addr0 !== 12'(e_addr) || wr_addr1 !== 12'(e_addr)) begin
          errors++;
          $display("FAIL wr_addr cyc %0d got %0d/%0d exp %0d", cyc, wr_addr0, wr_addr1, e_addr);
        end
        if (wr_data0 !== 13'(e_d0) || wr_data1 !== 13'(e_d1)) begin
          errors++;
          $display("FAIL wr_data addr %0d got %0d/%0d exp %0d/%0d", e_addr, wr_data0, wr_data1,
                   e_d0, e_d1);
        end
      end else begin
        checks++;
      end
      if (wr_en0 === 1'b1) begin
        mem0[wr_addr0] = wr_data0;
        g_nwr++;
        if (g_first_wr_after < 0 && g_ndone > 0) g_first_wr_after = cyc;
      end
      if (wr_en1 === 1'b1) mem1[wr_addr1] = wr_data1;
      if (done0 === 1'b1) begin
        if (g_ndone < 2) g_done_cyc[g_ndone] = cyc;
        g_ndone++;
      end

      cur_done = e_done;
      if (cur_done) frames_left--;
      start = (cyc == 0) || (cyc == extra_start) || (b2b && cur_done && frames_left > 0);
      rst = (cyc == rst_at);
      r = m_pos / W;
      c = m_pos % W;
      in_data = 13'($urandom_range(0, 8191));
      if (m_phase == 1 && is_interior(m_pos)) begin
        if (dmode == 1) in_data = 13'($urandom_range(0, 8191));
        else if (dmode == 2 && m_pos >= W + 1 && m_pos < W + 6) in_data = clamp_vec[m_pos - W - 1];
        else in_data = 13'(r * 100 + c);
      end
      in_valid = 1'b1;
      if (vmode == 1) in_valid = ($urandom_range(0, 3) != 0);
      if (vmode == 2 && m_phase == 1 && m_pos == 5 * W + 5 && stall_cnt < 10) begin
        in_valid = 1'b0;
        stall_cnt++;
      end
      if (in_valid && in_ready0 === 1'b1 && !rst) g_hs++;

      n_wr = 0; n_done = 0; n_a = 0; n_d0 = 0; n_d1 = 0;
      if (rst) begin
        m_phase = 0;
        m_pos = 0;
      end else if (m_phase == 0) begin
        if (start) begin
          m_phase = 1;
          m_pos = 0;
        end
      end else if (m_phase == 1) begin
        adv = 0;
        if (!is_interior(m_pos)) begin
          adv = 1; n_d0 = 0; n_d1 = 7;
        end else if (in_valid) begin
          adv = 1; n_d0 = clamp_ref(in_data); n_d1 = int'(in_data);
        end
        if (adv) begin
          n_wr = 1;
          n_a = m_pos;
          if (m_pos == NPIX - 1) m_phase = 2;
          else m_pos++;
        end
      end else begin
        n_done = 1;
        m_phase = 0;
      end
      e_wr = n_wr; e_addr = n_a; e_d0 = n_d0; e_d1 = n_d1; e_done = n_done;
      e_busy = (m_phase != 0);

      if (cur_done && frames_left == 0) fin = 1;
      if (rst_at >= 0 && cyc >= rst_at + 6) fin = 1;
      if (cyc >= 12000) begin
        checks++; errors++;
        $display("FAIL timeout cyc %0d got no frame end exp done", cyc);
        fin = 1;
      end
      cyc++;
    end
    start = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if ({wr_en0, wr_addr0, wr_data0, busy0, done0, in_ready0} !== '0) begin
      errors++; $display("FAIL reset_outputs0 got %0h exp 0",
                         {wr_en0, wr_addr0, wr_data0, busy0, done0, in_ready0});
    end
    if ({wr_en1, wr_addr1, wr_data1, busy1, done1, in_ready1} !== '0) begin
      errors++; $display("FAIL reset_outputs1 got %0h exp 0",
                         {wr_en1, wr_addr1, wr_data1, busy1, done1, in_ready1});
    end
    rst = 1'b0;
    m_phase = 0; m_pos = 0;
    e_wr = 0; e_done = 0; e_busy = 0; e_addr = 0; e_d0 = 0; e_d1 = 0;
  endtask

  task automatic test_full_frame();
    run_frame(0, 0, -1, -1, 0);
    checks += 7;
    if (g_nwr !== 4096) begin errors++; $display("FAIL full_nwr got %0d exp 4096", g_nwr); end
    if (g_hs !== 3844) begin errors++; $display("FAIL full_hs got %0d exp 3844", g_hs); end
    if (g_done_cyc[0] !== 4098) begin
      errors++; $display("FAIL full_done_cyc got %0d exp 4098", g_done_cyc[0]);
    end
    if (mem0[65] !== 13'd101) begin errors++; $display("FAIL full_a65 got %0d exp 101", mem0[65]); end
    if (mem1[65] !== 13'd101) begin errors++; $display("FAIL nc_a65 got %0d exp 101", mem1[65]); end
    if (mem0[0] !== 13'd0) begin errors++; $display("FAIL full_a0 got %0d exp 0", mem0[0]); end
    if (mem1[4030] !== 13'd6262) begin
      errors++; $display("FAIL nc_a4030 got %0d exp 6262", mem1[4030]);
    end
  endtask

  task automatic test_border();
    for (int a = 0; a < NPIX; a++) begin
      if (!is_interior(a)) begin
        checks += 2;
        if (mem1[a] !== 13'd7) begin
          errors++; $display("FAIL border7 addr %0d got %0d exp 7", a, mem1[a]);
        end
        if (mem0[a] !== 13'd0) begin
          errors++; $display("FAIL border0 addr %0d got %0d exp 0", a, mem0[a]);
        end
      end
    end
    checks++;
    if (g_ready_border !== 0) begin
      errors++; $display("FAIL border_ready got %0d exp 0", g_ready_border);
    end
  endtask

  task automatic test_clamp();
    int exp0 [5] = '{0, 0, 255, 255, 255};
    int exp1 [5] = '{8187, 0, 255, 300, 4095};
    run_frame(2, 0, -1, -1, 0);
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (mem0[65 + k] !== 13'(exp0[k])) begin
        errors++; $display("FAIL clamp%0d got %0d exp %0d", k, mem0[65 + k], exp0[k]);
      end
      if (mem1[65 + k] !== 13'(exp1[k])) begin
        errors++; $display("FAIL pass%0d got %0d exp %0d", k, mem1[65 + k], exp1[k]);
      end
    end
  endtask

  task automatic test_stall();
    run_frame(0, 2, -1, -1, 0);
    checks += 3;
    if (g_done_cyc[0] !== 4108) begin
      errors++; $display("FAIL stall_done_cyc got %0d exp 4108", g_done_cyc[0]);
    end
    if (mem1[325] !== 13'd505) begin
      errors++; $display("FAIL stall_a325 got %0d exp 505", mem1[325]);
    end
    if (g_nwr !== 4096) begin errors++; $display("FAIL stall_nwr got %0d exp 4096", g_nwr); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      run_frame(1, 1, -1, -1, 0);
      checks += 2;
      if (g_nwr !== 4096) begin errors++; $display("FAIL rand_nwr got %0d exp 4096", g_nwr); end
      if (g_hs !== 3844) begin errors++; $display("FAIL rand_hs got %0d exp 3844", g_hs); end
    end
  endtask

  task automatic test_reset_mid();
    run_frame(0, 0, 2000, -1, 0);
    checks += 2;
    if (g_ndone !== 0) begin errors++; $display("FAIL rstmid_done got %0d exp 0", g_ndone); end
    if (g_nwr !== 1999) begin errors++; $display("FAIL rstmid_nwr got %0d exp 1999", g_nwr); end
    run_frame(0, 0, -1, -1, 0);
    checks += 2;
    if (g_nwr !== 4096) begin errors++; $display("FAIL rstnew_nwr got %0d exp 4096", g_nwr); end
    if (g_done_cyc[0] !== 4098) begin
      errors++; $display("FAIL rstnew_done got %0d exp 4098", g_done_cyc[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, -1, 1000, 1);
    checks += 4;
    if (g_done_cyc[0] !== 4098) begin
      errors++; $display("FAIL b2b_done0 got %0d exp 4098", g_done_cyc[0]);
    end
    if (g_first_wr_after !== 4100) begin
      errors++; $display("FAIL b2b_first_wr got %0d exp 4100", g_first_wr_after);
    end
    if (g_done_cyc[1] !== 8196) begin
      errors++; $display("FAIL b2b_done1 got %0d exp 8196", g_done_cyc[1]);
    end
    if (g_nwr !== 8192) begin errors++; $display("FAIL b2b_nwr got %0d exp 8192", g_nwr); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_border();
    test_clamp();
    test_stall();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
